ps2_key_tracker: RTL and testbench

//  Sits between the PS/2 keyboard byte receiver and the game logic. Consumes one scan-code byte per

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_autofire.sv | 30 +++
 rtl/ps2_key_tracker.sv | 124 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix FSM state type and byte classifiers for the
// PS/2 key tracker.
package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_BAT  = 8'hAA;
    localparam logic [7:0] SC_ACK  = 8'hFA;
    localparam logic [7:0] SC_ECHO = 8'hEE;
    localparam logic [7:0] SC_RSND = 8'hFE;
    localparam logic [7:0] SC_PAUS = 8'hE1;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERRF = 8'hFF;
    localparam logic [7:0] SC_BATF = 8'hFC;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_FIRE  = 8'h29;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    // Keyboard housekeeping bytes: abandon any prefix but keep key state.
    function automatic logic is_ctrl_quiet(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_RSND) || (b == SC_PAUS);
    endfunction

    // Receiver/keyboard error bytes: key state can no longer be trusted.
    function automatic logic is_ctrl_err(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERRF) || (b == SC_BATF);
    endfunction

endpackage

// File: rtl/ps2_autofire.sv
// Repeat-strike generator: while fire is held, pulses strike every PERIOD cycles
// counted from the initial press.
module ps2_autofire #(
    parameter int PERIOD = 7500000
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    output logic strike
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !fire) begin
            cnt    <= '0;
            strike <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            strike <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            strike <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker for the left/right/fire game keys with prefix timeout.
// Define KEY_AUTOFIRE_EN to add repeat fire strikes while space is held.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter logic [7:0] LEFT_CODE      = KEY_LEFT,
    parameter logic [7:0] RIGHT_CODE     = KEY_RIGHT,
    parameter logic [7:0] FIRE_CODE      = KEY_FIRE,
    parameter int         PREFIX_TIMEOUT = 50000
`ifdef KEY_AUTOFIRE_EN
    ,
    parameter int         AUTOFIRE_PERIOD = 7500000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       left,
    output logic       right,
    output logic       fire,
    output logic       move_left,
    output logic       move_right,
    output logic       fire_strike,
    output logic       err,
    output ps2_state_t state
);

    localparam int TMO_W = $clog2(PREFIX_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             strike_q;

    // Every accepted byte leaves the FSM in IDLE unless it is a recognised prefix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            left     <= 1'b0;
            right    <= 1'b0;
            fire     <= 1'b0;
            strike_q <= 1'b0;
            err      <= 1'b0;
        end else begin
            strike_q <= 1'b0;
            err      <= 1'b0;
            if (scan_valid) begin
                tmo_cnt <= '0;
                state   <= IDLE;
                if (is_ctrl_err(scan_code)) begin
                    left  <= 1'b0;
                    right <= 1'b0;
                    fire  <= 1'b0;
                    err   <= 1'b1;
                end else if (!is_ctrl_quiet(scan_code)) begin
                    case (state)
                        IDLE: begin
                            if (scan_code == SC_EXT) begin
                                state <= EXT;
                            end else if (scan_code == SC_BRK) begin
                                state <= BRK;
                            end else if (scan_code == FIRE_CODE) begin
                                fire     <= 1'b1;
                                strike_q <= ~fire;
                            end
                        end
                        EXT: begin
                            if (scan_code == SC_BRK) begin
                                state <= EXT_BRK;
                            end else if (scan_code == LEFT_CODE) begin
                                left <= 1'b1;
                            end else if (scan_code == RIGHT_CODE) begin
                                right <= 1'b1;
                            end
                        end
                        BRK: begin
                            if (scan_code == FIRE_CODE) begin
                                fire <= 1'b0;
                            end
                        end
                        EXT_BRK: begin
                            if (scan_code == LEFT_CODE) begin
                                left <= 1'b0;
                            end else if (scan_code == RIGHT_CODE) begin
                                right <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                    err     <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    assign move_left  = left & ~right;
    assign move_right = right & ~left;

`ifdef KEY_AUTOFIRE_EN
    logic auto_strike;

    ps2_autofire #(
        .PERIOD (AUTOFIRE_PERIOD)
    ) u_autofire (
        .clk    (clk),
        .reset  (reset),
        .fire   (fire),
        .strike (auto_strike)
    );

    assign fire_strike = strike_q | auto_strike;
`else
    assign fire_strike = strike_q;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: driver pushes hand-computed expected outputs,
// a negedge monitor pops and compares. Build with KEY_AUTOFIRE_EN for the repeat test.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int W   = 9;
    localparam int TMO = 20;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       left, right, fire, move_left, move_right, fire_strike, err;
    ps2_state_t state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           passes;

    ps2_key_tracker #(
        .PREFIX_TIMEOUT (TMO)
`ifdef KEY_AUTOFIRE_EN
        ,
        .AUTOFIRE_PERIOD (10)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .left        (left),
        .right       (right),
        .fire        (fire),
        .move_left   (move_left),
        .move_right  (move_right),
        .fire_strike (fire_strike),
        .err         (err),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected vector: {left,right,fire,move_left,move_right,fire_strike,err,state}
    function automatic logic [W-1:0] ev(input logic l, input logic r, input logic f,
                                        input logic ml, input logic mr, input logic s,
                                        input logic e, input ps2_state_t st);
        return {l, r, f, ml, mr, s, e, st};
    endfunction

    task automatic step(input logic v, input logic [7:0] code, input logic chk,
                        input logic [W-1:0] e, input string nm);
        scan_valid = v;
        scan_code  = code;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic send(input logic [7:0] code);
        step(1'b1, code, 1'b0, '0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, '0, "");
    endtask

    // Monitor: compares the DUT outputs once per queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] act;
            string        nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {left, right, fire, move_left, move_right, fire_strike, err, state};
            checks++;
            if (act === e) passes++;
            else $display("FAIL %s: got %b expected %b (l r f ml mr strike err st)", nm, act, e);
        end
    end

    initial begin
        checks     = 0;
        passes     = 0;
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "reset");
        reset = 1'b0;

        // fire press, typematic repeats, break
        step(1'b1, 8'h29, 1'b1, ev(0,0,1,0,0,1,0,IDLE), "fire_make");
        step(1'b0, 8'h00, 1'b1, ev(0,0,1,0,0,0,0,IDLE), "strike_one_cycle");
        step(1'b1, 8'h29, 1'b1, ev(0,0,1,0,0,0,0,IDLE), "typematic1");
        step(1'b1, 8'h29, 1'b1, ev(0,0,1,0,0,0,0,IDLE), "typematic2");
        step(1'b1, 8'hF0, 1'b1, ev(0,0,1,0,0,0,0,BRK),  "fire_brk_prefix");
        step(1'b1, 8'h29, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "fire_break");

        // arrows
        step(1'b1, 8'hE0, 1'b1, ev(0,0,0,0,0,0,0,EXT),  "ext_prefix");
        step(1'b1, 8'h6B, 1'b1, ev(1,0,0,1,0,0,0,IDLE), "left_make");
        send(8'hE0);
        step(1'b1, 8'h74, 1'b1, ev(1,1,0,0,0,0,0,IDLE), "both_arrows");
        send(8'hE0);
        step(1'b1, 8'hF0, 1'b1, ev(1,1,0,0,0,0,0,EXT_BRK), "ext_brk_prefix");
        step(1'b1, 8'h6B, 1'b1, ev(0,1,0,0,1,0,0,IDLE), "left_break");
        send(8'hE0);
        send(8'hF0);
        step(1'b1, 8'h74, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "right_break");

        // wrong-prefix codes are other keys
        step(1'b1, 8'h6B, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "left_no_e0");
        step(1'b1, 8'h74, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "right_no_e0");
        send(8'hE0);
        step(1'b1, 8'h29, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "fire_after_e0");

        // prefix timeout
        send(8'hE0);
        idle(TMO - 2);
        step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,0,EXT),  "before_timeout");
        step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,1,IDLE), "timeout_err");
        step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "timeout_err_one_cycle");
        step(1'b1, 8'h6B, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "after_timeout_6b");
        send(8'hE0);
        idle(TMO - 1);
        step(1'b1, 8'h6B, 1'b1, ev(1,0,0,1,0,0,0,IDLE), "byte_wins_timeout");
        step(1'b0, 8'h00, 1'b1, ev(1,0,0,1,0,0,0,IDLE), "byte_wins_no_err");
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);

        // control bytes
        send(8'hE0);
        send(8'h6B);
        step(1'b1, 8'h29, 1'b1, ev(1,0,1,1,0,1,0,IDLE), "hold_left_fire");
        step(1'b1, 8'hFC, 1'b1, ev(0,0,0,0,0,0,1,IDLE), "fc_clears");
        step(1'b1, 8'hAA, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "aa_no_change");
        send(8'hE0);
        send(8'h74);
        send(8'hE0);
        step(1'b1, 8'hFA, 1'b1, ev(0,1,0,0,1,0,0,IDLE), "fa_drops_prefix");
        send(8'hE0);
        step(1'b1, 8'h00, 1'b1, ev(0,0,0,0,0,0,1,IDLE), "err00_in_ext");

        // reset between E0 and F0
        send(8'hE0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "mid_seq_reset");
        reset = 1'b0;
        step(1'b1, 8'hF0, 1'b1, ev(0,0,0,0,0,0,0,BRK),  "post_reset_f0");
        step(1'b1, 8'h6B, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "post_reset_6b");

`ifdef KEY_AUTOFIRE_EN
        step(1'b1, 8'h29, 1'b1, ev(0,0,1,0,0,1,0,IDLE), "af_t1");
        for (int t = 2; t <= 24; t++) begin
            step((t == 15), 8'h29, 1'b1,
                 ev(0,0,1,0,0,(t == 11 || t == 21),0,IDLE), $sformatf("af_t%0d", t));
        end
        step(1'b1, 8'hF0, 1'b1, ev(0,0,1,0,0,0,0,BRK),  "af_t25");
        step(1'b1, 8'h29, 1'b1, ev(0,0,0,0,0,0,0,IDLE), "af_t26");
        for (int t = 27; t <= 40; t++) begin
            step(1'b0, 8'h00, 1'b1, ev(0,0,0,0,0,0,0,IDLE), $sformatf("af_t%0d", t));
        end
`else
        step(1'b1, 8'h29, 1'b1, ev(0,0,1,0,0,1,0,IDLE), "single_strike");
        for (int t = 2; t <= 24; t++) begin
            step(1'b0, 8'h00, 1'b1, ev(0,0,1,0,0,0,0,IDLE), $sformatf("no_repeat_t%0d", t));
        end
        send(8'hF0);
        send(8'h29);
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
